ioctl_loader: RTL

//  Parametrised ioctl download front-end between the hps_io/Verilator ioctl byte stream and core memories.

---
 rtl/ioctl_loader_pkg.sv | 21 ++
 rtl/ioctl_word_packer.sv | 110 +++++++++++
 rtl/ioctl_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ioctl_loader_pkg.sv
// Shared types and byte-lane helpers for the ioctl download front-end.
// Lane mapping follows BIG_ENDIAN so that packer and top agree on word layout.
package ioctl_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_FLUSH,
        ST_HOLD
    } state_t;

    function automatic int lane_bits(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 0;
    endfunction

    function automatic int lane_offset(input int lane, input int bytes, input bit big_endian);
        return big_endian ? (bytes - 1 - lane) * 8 : lane * 8;
    endfunction

endpackage

// File: rtl/ioctl_word_packer.sv
// Word assembly buffer with a one-byte skid for a byte that arrives while a
// write is pending or that belongs to a different word than the buffer.
module ioctl_word_packer
    import ioctl_loader_pkg::*;
#(
    parameter int  DATA_W     = 16,
    parameter int  ADDR_W     = 25,
    parameter bit  BIG_ENDIAN = 1'b0,
    localparam int BYTES      = DATA_W / 8,
    localparam int LB         = lane_bits(BYTES)
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 store,
    input  logic                 skid_load,
    input  logic                 commit,
    input  logic [ADDR_W-1:0]    byte_addr,
    input  logic [7:0]           byte_data,
    output logic [ADDR_W-LB-1:0] word_addr,
    output logic [DATA_W-1:0]    word_data,
    output logic [BYTES-1:0]     word_be,
    output logic                 empty,
    output logic                 full,
    output logic                 mismatch,
    output logic                 last_lane,
    output logic                 skid_valid,
    output logic                 skid_last
);

    localparam int LBW = (LB > 0) ? LB : 1;

    logic [LBW-1:0]       lane;
    logic [LBW-1:0]       skid_lane;
    logic [ADDR_W-LB-1:0] waddr;
    logic [ADDR_W-LB-1:0] skid_waddr;
    logic [7:0]           skid_data;
    logic                 take_direct;

    assign waddr = byte_addr[ADDR_W-1:LB];

    generate
        if (LB > 0) begin : g_lane
            assign lane = byte_addr[LB-1:0];
        end else begin : g_single_lane
            assign lane = '0;
        end
    endgenerate

    assign empty       = ~|word_be;
    assign full        = word_be[BYTES-1];
    assign mismatch    = ~empty && (waddr != word_addr);
    assign last_lane   = (lane == LBW'(BYTES - 1));
    assign skid_last   = skid_valid && (skid_lane == LBW'(BYTES - 1));
    // A byte landing in the same cycle the buffer drains goes straight in.
    assign take_direct = commit && !skid_valid && skid_load;

    function automatic logic [DATA_W-1:0] place_byte(input logic [DATA_W-1:0] w,
                                                     input logic [LBW-1:0]    l,
                                                     input logic [7:0]        b);
        logic [DATA_W-1:0] r;
        r = w;
        for (int i = 0; i < BYTES; i++) begin
            if (l == LBW'(i)) begin
                r[lane_offset(i, BYTES, BIG_ENDIAN) +: 8] = b;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            word_addr  <= '0;
            word_data  <= '0;
            word_be    <= '0;
            skid_valid <= 1'b0;
            skid_lane  <= '0;
            skid_waddr <= '0;
            skid_data  <= '0;
        end else begin
            if (commit) begin
                if (skid_valid) begin
                    word_addr <= skid_waddr;
                    word_data <= place_byte('0, skid_lane, skid_data);
                    word_be   <= BYTES'(1) << skid_lane;
                end else if (skid_load) begin
                    word_addr <= waddr;
                    word_data <= place_byte('0, lane, byte_data);
                    word_be   <= BYTES'(1) << lane;
                end else begin
                    word_data <= '0;
                    word_be   <= '0;
                end
            end else if (store) begin
                word_addr <= waddr;
                word_data <= place_byte(word_data, lane, byte_data);
                word_be   <= word_be | (BYTES'(1) << lane);
            end

            if (skid_load && !take_direct) begin
                skid_valid <= 1'b1;
                skid_lane  <= lane;
                skid_waddr <= waddr;
                skid_data  <= byte_data;
            end else if (commit) begin
                skid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ioctl_loader.sv
// ioctl download front-end: packs the byte stream into words, writes them to the
// selected channel with ioctl_wait back-pressure and generates the core reset.
module ioctl_loader
    import ioctl_loader_pkg::*;
#(
    parameter int  DATA_W     = 16,
    parameter int  ADDR_W     = 25,
    parameter int  NUM_CH     = 4,
    parameter int  RST_HOLD   = 16,
    parameter bit  BIG_ENDIAN = 1'b0,
    localparam int BYTES      = DATA_W / 8,
    localparam int LB         = lane_bits(BYTES),
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [ADDR_W-1:0]    ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    input  logic [7:0]           ioctl_index,
    output logic                 ioctl_wait,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic [CH_W-1:0]      mem_ch,
    output logic [ADDR_W-LB-1:0] mem_addr,
    output logic [DATA_W-1:0]    mem_data,
    output logic [BYTES-1:0]     mem_be,
    output logic [NUM_CH-1:0]    loaded,
    output logic [ADDR_W-1:0]    byte_count,
    output logic                 core_reset_n
);

    localparam int CNT_W = $clog2(RST_HOLD + 1);

    state_t            state;
    logic              dl_prev;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  hold_cnt;
    logic [BYTES-1:0]  pk_be;
    logic              pk_empty;
    logic              pk_full;
    logic              pk_mismatch;
    logic              pk_last_lane;
    logic              pk_skid_valid;
    logic              pk_skid_last;
    logic              dl_rise;
    logic              idx_ok;
    logic              collect_wr;
    logic              store;
    logic              skid_load;
    logic              accept_wr;
    logic              commit;
    logic              launch_now;
    logic [ADDR_W-1:0] byte_next;

    assign dl_rise    = ioctl_download && !dl_prev;
    assign idx_ok     = ({24'd0, ioctl_index} < 32'(NUM_CH));
    assign collect_wr = (state == ST_COLLECT) && ioctl_wr && !pk_full;
    assign store      = collect_wr && !pk_mismatch;
    // Bytes that cannot join the buffer (other word, or a write in flight) park in the skid.
    assign skid_load  = ioctl_wr && !pk_skid_valid &&
                        (((state == ST_COLLECT) && (pk_full || pk_mismatch)) || (state == ST_WRITE));
    assign accept_wr  = store || skid_load;
    assign commit     = (state == ST_WRITE) && mem_req && mem_ack;
    assign launch_now = (store && pk_last_lane) || (collect_wr && pk_mismatch) ||
                        ((state == ST_COLLECT) && pk_full);
    assign byte_next  = ioctl_addr + ADDR_W'(1);

    assign mem_ch = ch;
    assign mem_be = mem_req ? pk_be : '0;

    ioctl_word_packer #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .store      (store),
        .skid_load  (skid_load),
        .commit     (commit),
        .byte_addr  (ioctl_addr),
        .byte_data  (ioctl_dout),
        .word_addr  (mem_addr),
        .word_data  (mem_data),
        .word_be    (pk_be),
        .empty      (pk_empty),
        .full       (pk_full),
        .mismatch   (pk_mismatch),
        .last_lane  (pk_last_lane),
        .skid_valid (pk_skid_valid),
        .skid_last  (pk_skid_last)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_HOLD;
            hold_cnt     <= CNT_W'(RST_HOLD);
            dl_prev      <= 1'b0;
            ch           <= '0;
            ioctl_wait   <= 1'b0;
            mem_req      <= 1'b0;
            loaded       <= '0;
            byte_count   <= '0;
            core_reset_n <= 1'b0;
        end else begin
            dl_prev <= ioctl_download;
            if (accept_wr && (byte_next > byte_count)) begin
                byte_count <= byte_next;
            end

            case (state)
                ST_IDLE: begin
                    if (dl_rise && idx_ok) begin
                        ch                              <= ioctl_index[CH_W-1:0];
                        loaded[ioctl_index[CH_W-1:0]]   <= 1'b0;
                        byte_count                      <= '0;
                        core_reset_n                    <= 1'b0;
                        ioctl_wait                      <= 1'b0;
                        state                           <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (launch_now) begin
                        mem_req    <= 1'b1;
                        ioctl_wait <= 1'b1;
                        state      <= ST_WRITE;
                    end else if (!ioctl_download && !accept_wr) begin
                        if (!pk_empty) begin
                            state <= ST_FLUSH;
                        end else begin
                            loaded[ch] <= 1'b1;
                            hold_cnt   <= CNT_W'(RST_HOLD);
                            state      <= ST_HOLD;
                        end
                    end
                end
                ST_WRITE: begin
                    if (commit) begin
                        mem_req    <= 1'b0;
                        ioctl_wait <= pk_skid_last;
                        state      <= ioctl_download ? ST_COLLECT : ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!pk_empty) begin
                        mem_req    <= 1'b1;
                        ioctl_wait <= 1'b1;
                        state      <= ST_WRITE;
                    end else begin
                        loaded[ch] <= 1'b1;
                        hold_cnt   <= CNT_W'(RST_HOLD);
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    core_reset_n <= 1'b0;
                    if (dl_rise && idx_ok) begin
                        ch                              <= ioctl_index[CH_W-1:0];
                        loaded[ioctl_index[CH_W-1:0]]   <= 1'b0;
                        byte_count                      <= '0;
                        ioctl_wait                      <= 1'b0;
                        state                           <= ST_COLLECT;
                    end else if (hold_cnt <= CNT_W'(1)) begin
                        core_reset_n <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
